// File: rtl/hc191_updown_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hc191_updown_if                                                       |
// | Control/data bundle for one presettable up/down counter stage.       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
interface hc191_updown_if #(
   parameter int WIDTH = 4
);
   logic             CEP;
   logic             CET;
   logic             UD;
   logic             PE;
   logic [0:WIDTH-1] D;
   logic [0:WIDTH-1] Q;
   logic             TC;
   logic             RC;

   modport master (
      output CEP, CET, UD, PE, D,
      input  Q, TC, RC
   );

   modport slave (
      input  CEP, CET, UD, PE, D,
      output Q, TC, RC
   );
endinterface
`default_nettype wire

// File: rtl/hc191_updown.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hc191_updown                                                          |
// | Presettable synchronous binary up/down counter with cascade TC and    |
// | registered wrap pulse RC.                                             |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module hc191_updown #(
   parameter int WIDTH = 4
) (
   input  wire logic      CP,
   input  wire logic      MR,
   hc191_updown_if.slave  bus
);
   localparam logic [0:WIDTH-1] c_ONE  = WIDTH'(1);
   localparam logic [0:WIDTH-1] c_ZERO = '0;
   localparam logic [0:WIDTH-1] c_ONES = '1;

   logic [0:WIDTH-1] r_q;
   logic             r_rc;
   logic [0:WIDTH-1] w_terminal;
   logic             w_at_term;
   logic             w_count;

   // Terminal value follows the direction currently selected.
   assign w_terminal = bus.UD ? c_ZERO : c_ONES;
   assign w_at_term  = (r_q == w_terminal);
   assign w_count    = bus.CEP & bus.CET;

   always_ff @(posedge CP or negedge MR) begin
      if (!MR) begin
         r_q  <= c_ZERO;
         r_rc <= 1'b0;
      end else if (!bus.PE) begin
         r_q  <= bus.D;
         r_rc <= 1'b0;
      end else if (w_count) begin
         r_q  <= bus.UD ? (r_q - c_ONE) : (r_q + c_ONE);
         // A count step taken from the terminal value is exactly a wrap.
         r_rc <= w_at_term;
      end else begin
         r_rc <= 1'b0;
      end
   end

   assign bus.Q  = r_q;
   assign bus.TC = bus.CET & w_at_term;
   assign bus.RC = r_rc;
endmodule
`default_nettype wire

// File: tb/tb_hc191_updown.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hc191_updown                                                       |
// | Directed bench for hc191_updown with an arithmetic reference model.  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_hc191_updown;
   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic CP;
   logic MR;
   int   n_vec;
   int   n_err;

   hc191_updown_if #(.WIDTH(W)) bus  ();
   hc191_updown_if #(.WIDTH(W)) busL ();
   hc191_updown_if #(.WIDTH(W)) busH ();

   hc191_updown #(.WIDTH(W)) dut   (.CP(CP), .MR(MR), .bus(bus));
   hc191_updown #(.WIDTH(W)) dut_l (.CP(CP), .MR(MR), .bus(busL));
   hc191_updown #(.WIDTH(W)) dut_h (.CP(CP), .MR(MR), .bus(busH));

   assign busH.CET = busL.TC;

   initial CP = 1'b0;
   always #5 CP = ~CP;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain modular arithmetic, wrap seen as the value jumping backwards/forwards.
   int m_q, m_rc, m8, m_rcl, m_rch;
   always @(posedge CP or negedge MR) begin
      int nxt;
      if (MR !== 1'b1) begin
         m_q = 0; m_rc = 0; m8 = 0; m_rcl = 0; m_rch = 0;
      end else begin
         m_rc = 0;
         if (bus.PE === 1'b0) begin
            m_q = int'(bus.D);
         end else if (bus.CEP && bus.CET) begin
            nxt  = bus.UD ? (m_q + MOD - 1) % MOD : (m_q + 1) % MOD;
            m_rc = bus.UD ? int'(nxt > m_q) : int'(nxt < m_q);
            m_q  = nxt;
         end
         m_rcl = 0;
         m_rch = 0;
         if (busL.CEP) begin
            nxt   = (m8 + 1) % 256;
            m_rcl = int'((nxt % 16) < (m8 % 16));
            m_rch = int'(nxt < m8);
            m8    = nxt;
         end
      end
   end

   always @(negedge CP) begin
      int term;
      term = bus.UD ? 0 : MOD - 1;
      chk("model_q",  32'(bus.Q),  32'(m_q));
      chk("model_tc", 32'(bus.TC), 32'(bus.CET && (m_q == term)));
      chk("model_rc", 32'(bus.RC), 32'(m_rc));
      chk("casc_q",   32'({busH.Q, busL.Q}), 32'(m8));
      chk("casc_rcl", 32'(busL.RC), 32'(m_rcl));
      chk("casc_rch", 32'(busH.RC), 32'(m_rch));
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CP);
         #2;
      end
   endtask

   logic [3:0] exp_dn [4];

   initial begin
      n_vec = 0;
      n_err = 0;
      MR = 1'b0;
      bus.CEP = 1'b0; bus.CET = 1'b1; bus.UD = 1'b0; bus.PE = 1'b1; bus.D = '0;
      busL.CEP = 1'b0; busL.CET = 1'b1; busL.UD = 1'b0; busL.PE = 1'b1; busL.D = '0;
      busH.CEP = 1'b0; busH.UD = 1'b0; busH.PE = 1'b1; busH.D = '0;
      tick(2);

      // Reset state
      chk("rst_q",  32'(bus.Q),  32'd0);
      chk("rst_rc", 32'(bus.RC), 32'd0);
      chk("rst_tc_up", 32'(bus.TC), 32'd0);
      bus.UD = 1'b1;
      #1 chk("rst_tc_dn", 32'(bus.TC), 32'd1);
      bus.UD = 1'b0;

      // Up count through the wrap
      MR = 1'b1;
      bus.CEP = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         tick(1);
         chk("up_q",  32'(bus.Q),  32'(i % 16));
         chk("up_tc", 32'(bus.TC), 32'((i % 16) == 15));
         chk("up_rc", 32'(bus.RC), 32'(i == 16));
      end

      // Down count from a preset of 2
      bus.PE = 1'b0; bus.D = 4'b0010;
      tick(1);
      chk("load2_q", 32'(bus.Q), 32'd2);
      bus.PE = 1'b1; bus.UD = 1'b1;
      exp_dn = '{4'd1, 4'd0, 4'd15, 4'd14};
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("dn_q",  32'(bus.Q),  32'(exp_dn[i]));
         chk("dn_tc", 32'(bus.TC), 32'(exp_dn[i] == 4'd0));
         chk("dn_rc", 32'(bus.RC), 32'(i == 2));
      end

      // Enables, load priority, direction change
      bus.PE = 1'b0; bus.D = 4'd7; bus.UD = 1'b0;
      tick(1);
      bus.PE = 1'b1; bus.CEP = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("cep_hold", 32'(bus.Q), 32'd7);
      end
      bus.CEP = 1'b1; bus.CET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("cet_hold", 32'(bus.Q), 32'd7);
         chk("cet_tc",   32'(bus.TC), 32'd0);
      end
      bus.CET = 1'b1; bus.PE = 1'b0; bus.D = 4'b1010;
      tick(1);
      chk("load_pri", 32'(bus.Q), 32'd10);
      bus.PE = 1'b1;
      tick(1); chk("dir_up1", 32'(bus.Q), 32'd11);
      tick(1); chk("dir_up2", 32'(bus.Q), 32'd12);
      bus.UD = 1'b1;
      tick(1); chk("dir_dn1", 32'(bus.Q), 32'd11);
      tick(1); chk("dir_dn2", 32'(bus.Q), 32'd10);

      // Asynchronous reset mid-count
      bus.UD = 1'b0; bus.PE = 1'b0; bus.D = 4'd8;
      tick(1);
      bus.PE = 1'b1;
      tick(1);
      chk("pre_rst_q", 32'(bus.Q), 32'd9);
      #2 MR = 1'b0;
      #1;
      chk("arst_q",  32'(bus.Q),  32'd0);
      chk("arst_rc", 32'(bus.RC), 32'd0);
      tick(1);
      MR = 1'b1;
      tick(1);
      chk("post_rst_q", 32'(bus.Q), 32'd1);

      // Two-stage cascade, 8 bits
      bus.CEP = 1'b0;
      busL.CEP = 1'b1; busH.CEP = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         tick(1);
         chk("casc_cnt", 32'({busH.Q, busL.Q}), 32'(i % 256));
         chk("casc_rc",  32'(busH.RC), 32'(i == 256));
      end
      busL.CEP = 1'b0; busH.CEP = 1'b0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/hc191_updown.md
# hc191_updown

Presettable synchronous binary up/down counter, companion to the 74HC161-style up counter in the same FPGA logic library. It counts in both directions, loads synchronously, and flags the terminal count for the selected direction. Stages cascade through CET/TC exactly like the up counter, so down-counting dividers and timers can be built from chained instances. A registered wrap pulse (RC) drives downstream single-cycle events.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.

Ports:
- CP  input  1  clock; all state changes on the rising edge.
- MR  input  1  master reset; asynchronous, active-low.
- CEP  input  1  count enable (parallel); active-high.
- CET  input  1  count enable (trickle/cascade); active-high; also gates TC.
- UD  input  1  direction: 0 = up, 1 = down.
- PE  input  1  parallel load enable; synchronous, active-low.
- D  input  [0:WIDTH-1]  preset value; D[0] is the MSB, D[WIDTH-1] is the LSB.
- Q  output  [0:WIDTH-1]  counter value; Q[0] is the MSB, Q[WIDTH-1] is the LSB.
- TC  output  1  terminal count; combinational.
- RC  output  1  wrap pulse; registered, one cycle wide.

## Operation
- Priority per rising CP edge: MR low > PE low (load) > count (CEP & CET) > hold.
- MR low: Q and RC clear to 0 immediately, with no clock required. While MR is low, the counter ignores all other inputs.
- PE low: Q <= D on the edge, regardless of CEP, CET and UD. RC <= 0.
- Count, when PE is high and CEP & CET is 1:
  - UD=0: Q <= Q+1, modulo 2^WIDTH.
  - UD=1: Q <= Q-1, modulo 2^WIDTH.
- Hold, when PE is high and CEP & CET is 0: Q is unchanged and RC <= 0.
- Terminal value: all-ones when UD=0, all-zeros when UD=1.
- TC = CET & (Q == terminal value for the current UD). TC does not depend on CEP or PE.
- RC <= 1 on an edge where a count step wraps: Q goes from all-ones to 0 (up) or from 0 to all-ones (down). On every other edge RC <= 0.
  - A load that happens to move Q across the wrap boundary does not set RC.
- Direction change: UD is combinational into TC and is sampled into the next-state logic at the edge. No pipeline, no lost or double step.
- Cascading: connect stage n TC to stage n+1 CET, and drive CEP of all stages in common. All stages share CP and MR.
- There are no other internal states. The block is a single WIDTH-bit register plus the RC flop.

## Timing
- Reset values: Q = 0, RC = 0.
  - TC after reset = CET & UD, since Q=0 is the terminal value only when counting down.
- Count/load latency: Q updates 1 cycle after the qualifying edge, clock-to-out from a flop.
- TC latency: combinational from Q, UD and CET, within the same cycle. It has no registered delay.
- RC latency: high during the cycle that immediately follows the wrapping edge, for exactly 1 cycle.
  - With continuous counting it pulses once every 2^WIDTH cycles.
- Asynchronous reset assert: Q and RC go to 0 without a clock.
- Reset deassert: the first count or load occurs on the first CP edge after MR goes high. MR must meet recovery time to CP.
- Reset during a count or load: the reset wins and the edge is discarded.
- Simultaneous PE low with CEP=CET=1: the load wins and Q = D.
- All synchronous inputs need setup/hold to the CP rising edge. There are no combinational paths from inputs to Q.

## Test plan
- Reset and up count:
  - Stimulus: MR=0, then release; CEP=CET=1, UD=0, PE=1, WIDTH=4, for 17 edges.
  - Required: Q steps 0,1,…,15,0,1. TC=1 only while Q=15. RC=1 for exactly the one cycle after the 15→0 edge.
- Down count and wrap:
  - Stimulus: load D=4'b0010 with PE=0, then UD=1 and count for 4 edges.
  - Required: Q goes 2,1,0,15,14. TC=1 only while Q=0. RC pulses once, after the 0→15 edge.
- Enables, load priority and direction change:
  - Stimulus: at Q=7, CEP=0 for 3 edges; then CET=0 for 3 edges; then PE=0 with D=4'b1010 and CEP=CET=1; then flip UD mid-run.
  - Required: Q holds at 7 for all 6 edges, with TC=0 while CET=0. Q=10 after the load. The count direction reverses on the first edge after UD changes, with no skipped value.
- Async reset mid-count:
  - Stimulus: assert MR=0 between edges while Q=9.
  - Required: Q=0 and RC=0 before the next edge. The first edge after release gives Q=1 when UD=0.
- Two-stage cascade, 8 bits total:
  - Stimulus: count up from 0x00 through 0xFF to 0x00.
  - Required: the upper stage increments only on lower-stage TC. The combined Q runs 0x00–0xFF and wraps. The upper-stage RC pulses once, after the 0xFF→0x00 edge.
